// File: rtl/shift_register_8bit_if.sv
// Data/control bundle of the universal shift register. The parent (master) drives mode and data;
// the register (slave) returns its contents.
interface shift_register_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA_IN;
  logic             S_DATA_IN;
  logic             SH_LD;
  logic [WIDTH-1:0] P_DATA_OUT;

  modport master (
    output P_DATA_IN,
    output S_DATA_IN,
    output SH_LD,
    input  P_DATA_OUT
  );

  modport slave (
    input  P_DATA_IN,
    input  S_DATA_IN,
    input  SH_LD,
    output P_DATA_OUT
  );
endinterface

// File: rtl/shift_register_8bit.sv
// Universal shift register: synchronous clear, parallel load (SH_LD=0) or serial shift (SH_LD=1).
// Define SHIFT_REGISTER_8BIT_MSB_FIRST_EN to shift left (serial in at bit 0, serial out at MSB).
module shift_register_8bit #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 CLK,
  input  logic                 CLR,
  shift_register_8bit_if.slave bus
);

  generate
    if (WIDTH < 2) begin : g_width_check
      $fatal(1, "shift_register_8bit: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  // CLR beats load, load beats shift; there is no hold mode, the parent stops CLK instead.
  always_comb begin
    w_q_next = r_q;
    if (CLR) begin
      w_q_next = RESET_VALUE;
    end else if (!bus.SH_LD) begin
      w_q_next = bus.P_DATA_IN;
    end else begin
`ifdef SHIFT_REGISTER_8BIT_MSB_FIRST_EN
      w_q_next = {r_q[WIDTH-2:0], bus.S_DATA_IN};
`else
      w_q_next = {bus.S_DATA_IN, r_q[WIDTH-1:1]};
`endif
    end
  end

  always_ff @(posedge CLK) begin
    r_q <= w_q_next;
  end

  assign bus.P_DATA_OUT = r_q;

endmodule

// File: tb/tb_shift_register_8bit.sv
// Directed self-checking bench for shift_register_8bit (default LSB-first build).
module tb_shift_register_8bit;

  logic r_clk;
  logic r_clk_en;
  logic w_clk;
  logic r_clr;
  int   checks;
  int   errors;

  shift_register_8bit_if #(.WIDTH(8)) bus ();

  shift_register_8bit #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .CLK(w_clk),
    .CLR(r_clr),
    .bus(bus)
  );

  // Gated clock: enable is only changed while r_clk is low, so no glitches.
  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end
  assign w_clk = r_clk & r_clk_en;

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic clr, input logic sh_ld, input logic sin, input logic [7:0] pin);
    r_clr         = clr;
    bus.SH_LD     = sh_ld;
    bus.S_DATA_IN = sin;
    bus.P_DATA_IN = pin;
    @(negedge r_clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 8'h00);
    checks++;
    if (bus.P_DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL reset_from_x: got %h expected %h", bus.P_DATA_OUT, 8'h00);
    end
    step(1'b0, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    checks++;
    if (bus.P_DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL reset_beats_load: got %h expected %h", bus.P_DATA_OUT, 8'h00);
    end
  endtask

  task automatic test_load();
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    checks++;
    if (bus.P_DATA_OUT !== 8'hA5) begin
      errors++;
      $display("FAIL load_a5: got %h expected %h", bus.P_DATA_OUT, 8'hA5);
    end
    step(1'b0, 1'b0, 1'b0, 8'h3C);
    checks++;
    if (bus.P_DATA_OUT !== 8'h3C) begin
      errors++;
      $display("FAIL load_3c: got %h expected %h", bus.P_DATA_OUT, 8'h3C);
    end
  endtask

  task automatic test_serial_out();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;  // bit0 first: 1,0,1,0,0,1,0,1
    step(1'b0, 1'b0, 1'b0, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.P_DATA_OUT[0] !== exp_bits[k]) begin
        errors++;
        $display("FAIL serial_out_bit%0d: got %b expected %b", k, bus.P_DATA_OUT[0], exp_bits[k]);
      end
      step(1'b0, 1'b1, 1'b0, 8'hxx);
    end
    checks++;
    if (bus.P_DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL serial_out_final: got %h expected %h", bus.P_DATA_OUT, 8'h00);
    end
  endtask

  task automatic test_serial_in();
    logic [7:0] sin_seq;
    sin_seq = 8'b0100_1011;  // index 0 applied first: 1,1,0,1,0,0,1,0
    step(1'b1, 1'b1, 1'b0, 8'hxx);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, sin_seq[k], 8'hzz);
    end
    checks++;
    if (bus.P_DATA_OUT !== 8'h4B) begin
      errors++;
      $display("FAIL serial_in: got %h expected %h", bus.P_DATA_OUT, 8'h4B);
    end
  endtask

  task automatic test_clock_stop();
    step(1'b0, 1'b0, 1'b0, 8'h3C);
    r_clk_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.SH_LD     = k[0];
      bus.S_DATA_IN = ~k[0];
      bus.P_DATA_IN = 8'(k * 37);
      r_clr         = 1'b0;
      #7;
    end
    @(negedge r_clk);
    checks++;
    if (bus.P_DATA_OUT !== 8'h3C) begin
      errors++;
      $display("FAIL clock_stop_hold: got %h expected %h", bus.P_DATA_OUT, 8'h3C);
    end
    r_clk_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h00);
    checks++;
    if (bus.P_DATA_OUT !== 8'h9E) begin
      errors++;
      $display("FAIL clock_stop_resume: got %h expected %h", bus.P_DATA_OUT, 8'h9E);
    end
  endtask

  task automatic test_reset_mid_shift();
    step(1'b0, 1'b0, 1'b0, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checks++;
    if (bus.P_DATA_OUT !== 8'h1F) begin
      errors++;
      $display("FAIL mid_shift_value: got %h expected %h", bus.P_DATA_OUT, 8'h1F);
    end
    step(1'b1, 1'b1, 1'b1, 8'h00);
    checks++;
    if (bus.P_DATA_OUT !== 8'h00) begin
      errors++;
      $display("FAIL mid_shift_clear: got %h expected %h", bus.P_DATA_OUT, 8'h00);
    end
    step(1'b0, 1'b0, 1'b0, 8'h81);
    checks++;
    if (bus.P_DATA_OUT !== 8'h81) begin
      errors++;
      $display("FAIL reload_after_clear: got %h expected %h", bus.P_DATA_OUT, 8'h81);
    end
  endtask

  task automatic test_back_to_back();
    // Shifting past WIDTH: old bits fall off bit 0, ones fill from the top.
    step(1'b0, 1'b0, 1'b0, 8'h0F);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    checks++;
    if (bus.P_DATA_OUT !== 8'h87) begin
      errors++;
      $display("FAIL b2b_first_shift: got %h expected %h", bus.P_DATA_OUT, 8'h87);
    end
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00);
    end
    checks++;
    if (bus.P_DATA_OUT !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_overflow: got %h expected %h", bus.P_DATA_OUT, 8'hFF);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h66);
    checks++;
    if (bus.P_DATA_OUT !== 8'h66) begin
      errors++;
      $display("FAIL b2b_load_after_shift: got %h expected %h", bus.P_DATA_OUT, 8'h66);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (bus.P_DATA_OUT !== 8'h33) begin
      errors++;
      $display("FAIL b2b_shift_after_load: got %h expected %h", bus.P_DATA_OUT, 8'h33);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    r_clk_en      = 1'b1;
    r_clr         = 1'b0;
    bus.SH_LD     = 1'b1;
    bus.S_DATA_IN = 1'b0;
    bus.P_DATA_IN = 8'h00;
    @(negedge r_clk);
    test_reset();
    test_load();
    test_serial_out();
    test_serial_in();
    test_clock_stop();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
